clock_ctrl: RTL and testbench

Time-of-day sequencer for the digital clock: owns the six BCD digit registers (HH:MM:SS, 24 h), advances them on a 1 Hz tick, and runs the mode FSM used to set hours and minutes from two push-buttons. Sits between the prescaler/button-conditioning logic and the 7-segment display driver. It also provides a per-digit blank mask so the display can blink the field being edited.

---
 rtl/clock_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_clock_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// Time-of-day sequencer: BCD HH:MM:SS registers, RUN/SET_HR/SET_MIN mode FSM, blink mask.
// Optional set-mode auto-exit is enabled by defining CLOCK_SET_TIMEOUT_EN.
module clock_ctrl #(
  parameter int unsigned SET_TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] h_tens,
  output logic [3:0] h_units,
  output logic [3:0] m_tens,
  output logic [3:0] m_units,
  output logic [3:0] s_tens,
  output logic [3:0] s_units,
  output logic [1:0] mode,
  output logic [5:0] blank
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10
  } state_t;

  if (SET_TIMEOUT < 2 || SET_TIMEOUT > 63) begin : g_bad_timeout
    $error("clock_ctrl: SET_TIMEOUT must be in 2..63");
  end

  state_t     r_state, w_state_nxt;
  logic [3:0] r_ht, r_hu, r_mt, r_mu, r_st, r_su;
  logic [3:0] w_ht_nxt, w_hu_nxt, w_mt_nxt, w_mu_nxt, w_st_nxt, w_su_nxt;
  logic       r_phase, w_phase_nxt;
  logic [5:0] r_blank, w_blank_nxt;
  logic       w_sec_inc, w_sec_clr, w_min_inc, w_hr_inc;
  logic       w_sec_wrap, w_min_wrap;
`ifdef CLOCK_SET_TIMEOUT_EN
  localparam logic [5:0] TO_LAST = 6'(SET_TIMEOUT - 1);
  logic [5:0] r_to_cnt, w_to_cnt_nxt;
`endif

  assign w_sec_wrap = (r_st == 4'd5) && (r_su == 4'd9);
  assign w_min_wrap = (r_mt == 4'd5) && (r_mu == 4'd9);

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_sec_inc   = 1'b0;
    w_sec_clr   = 1'b0;
    w_min_inc   = 1'b0;
    w_hr_inc    = 1'b0;
    w_ht_nxt    = r_ht;
    w_hu_nxt    = r_hu;
    w_mt_nxt    = r_mt;
    w_mu_nxt    = r_mu;
    w_st_nxt    = r_st;
    w_su_nxt    = r_su;
    w_blank_nxt = '0;
`ifdef CLOCK_SET_TIMEOUT_EN
    w_to_cnt_nxt = r_to_cnt;
`endif

    case (r_state)
      ST_RUN: begin
        // tick and btn_mode on the same edge both take effect
        if (tick) begin
          w_sec_inc = 1'b1;
          w_min_inc = w_sec_wrap;
          w_hr_inc  = w_sec_wrap & w_min_wrap;
        end
        if (btn_mode) begin
          w_state_nxt = ST_SET_HR;
          w_phase_nxt = 1'b0;
        end
      end
      ST_SET_HR, ST_SET_MIN: begin
        if (btn_mode) begin
          w_phase_nxt = 1'b0;
          if (r_state == ST_SET_HR) begin
            w_state_nxt = ST_SET_MIN;
          end else begin
            w_state_nxt = ST_RUN;
            w_sec_clr   = 1'b1;
          end
        end else if (btn_inc) begin
          w_phase_nxt = 1'b0;
          if (r_state == ST_SET_HR) w_hr_inc  = 1'b1;
          else                      w_min_inc = 1'b1;
        end else if (tick) begin
          w_phase_nxt = ~r_phase;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_phase_nxt = 1'b0;
      end
    endcase

`ifdef CLOCK_SET_TIMEOUT_EN
    if (r_state == ST_RUN || btn_mode || btn_inc) begin
      w_to_cnt_nxt = '0;
    end else if (tick) begin
      if (r_to_cnt == TO_LAST) begin
        w_to_cnt_nxt = '0;
        w_state_nxt  = ST_RUN;
        w_sec_clr    = 1'b1;
        w_phase_nxt  = 1'b0;
      end else begin
        w_to_cnt_nxt = r_to_cnt + 6'd1;
      end
    end
`endif

    if (w_sec_clr) begin
      w_st_nxt = '0;
      w_su_nxt = '0;
    end else if (w_sec_inc) begin
      if (r_su != 4'd9) begin
        w_su_nxt = r_su + 4'd1;
      end else begin
        w_su_nxt = '0;
        w_st_nxt = (r_st == 4'd5) ? 4'd0 : r_st + 4'd1;
      end
    end

    if (w_min_inc) begin
      if (r_mu != 4'd9) begin
        w_mu_nxt = r_mu + 4'd1;
      end else begin
        w_mu_nxt = '0;
        w_mt_nxt = (r_mt == 4'd5) ? 4'd0 : r_mt + 4'd1;
      end
    end

    if (w_hr_inc) begin
      if (r_ht == 4'd2 && r_hu == 4'd3) begin
        w_ht_nxt = '0;
        w_hu_nxt = '0;
      end else if (r_hu == 4'd9) begin
        w_ht_nxt = r_ht + 4'd1;
        w_hu_nxt = '0;
      end else begin
        w_hu_nxt = r_hu + 4'd1;
      end
    end

    // blank is registered from next-state values so it changes on the causing edge
    if (w_phase_nxt) begin
      case (w_state_nxt)
        ST_SET_HR:  w_blank_nxt = 6'b110000;
        ST_SET_MIN: w_blank_nxt = 6'b001100;
        default:    w_blank_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_ht    <= '0;
      r_hu    <= '0;
      r_mt    <= '0;
      r_mu    <= '0;
      r_st    <= '0;
      r_su    <= '0;
      r_phase <= 1'b0;
      r_blank <= '0;
`ifdef CLOCK_SET_TIMEOUT_EN
      r_to_cnt <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_ht    <= w_ht_nxt;
      r_hu    <= w_hu_nxt;
      r_mt    <= w_mt_nxt;
      r_mu    <= w_mu_nxt;
      r_st    <= w_st_nxt;
      r_su    <= w_su_nxt;
      r_phase <= w_phase_nxt;
      r_blank <= w_blank_nxt;
`ifdef CLOCK_SET_TIMEOUT_EN
      r_to_cnt <= w_to_cnt_nxt;
`endif
    end
  end

  assign h_tens  = r_ht;
  assign h_units = r_hu;
  assign m_tens  = r_mt;
  assign m_units = r_mu;
  assign s_tens  = r_st;
  assign s_units = r_su;
  assign mode    = r_state;
  assign blank   = r_blank;

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: directed steps with randomized gaps/buttons, checked
// against a seconds-of-day reference model. Honors CLOCK_SET_TIMEOUT_EN like the design.
module tb_clock_ctrl;

  localparam int TO = 30;

  logic       clk = 1'b0;
  logic       rst_n, tick, btn_mode, btn_inc;
  logic [3:0] h_tens, h_units, m_tens, m_units, s_tens, s_units;
  logic [1:0] mode;
  logic [5:0] blank;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int   t_sec;
  int   m_mode;
  logic m_ph;
`ifdef CLOCK_SET_TIMEOUT_EN
  int   m_cnt;
`endif

  clock_ctrl #(.SET_TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .h_tens   (h_tens),
    .h_units  (h_units),
    .m_tens   (m_tens),
    .m_units  (m_units),
    .s_tens   (s_tens),
    .s_units  (s_units),
    .mode     (mode),
    .blank    (blank)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    t_sec  = 0;
    m_mode = 0;
    m_ph   = 1'b0;
`ifdef CLOCK_SET_TIMEOUT_EN
    m_cnt  = 0;
`endif
  endtask

  task automatic model_step(input logic tk, input logic md, input logic ic);
    int h, mi, s;
    h  = t_sec / 3600;
    mi = (t_sec / 60) % 60;
    s  = t_sec % 60;
    if (m_mode == 0) begin
      if (tk) t_sec = (t_sec + 1) % 86400;
      if (md) begin
        m_mode = 1;
        m_ph   = 1'b0;
`ifdef CLOCK_SET_TIMEOUT_EN
        m_cnt  = 0;
`endif
      end
    end else if (md) begin
      if (m_mode == 1) m_mode = 2;
      else begin
        m_mode = 0;
        t_sec  = t_sec - s;
      end
      m_ph = 1'b0;
`ifdef CLOCK_SET_TIMEOUT_EN
      m_cnt = 0;
`endif
    end else if (ic) begin
      if (m_mode == 1) t_sec = ((h + 1) % 24) * 3600 + mi * 60 + s;
      else             t_sec = h * 3600 + ((mi + 1) % 60) * 60 + s;
      m_ph = 1'b0;
`ifdef CLOCK_SET_TIMEOUT_EN
      m_cnt = 0;
`endif
    end else if (tk) begin
      m_ph = ~m_ph;
`ifdef CLOCK_SET_TIMEOUT_EN
      m_cnt++;
      if (m_cnt == TO) begin
        m_mode = 0;
        t_sec  = t_sec - (t_sec % 60);
        m_ph   = 1'b0;
        m_cnt  = 0;
      end
`endif
    end
  endtask

  task automatic check(input string tag);
    int h, mi, s;
    logic [23:0] exp_d;
    logic [23:0] got_d;
    logic [1:0]  exp_m;
    logic [5:0]  exp_b;
    h  = t_sec / 3600;
    mi = (t_sec / 60) % 60;
    s  = t_sec % 60;
    exp_d = {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
    got_d = {h_tens, h_units, m_tens, m_units, s_tens, s_units};
    exp_m = 2'(m_mode);
    exp_b = !m_ph ? 6'b000000 : (m_mode == 1) ? 6'b110000 : (m_mode == 2) ? 6'b001100 : 6'b000000;
    n_cmp++;
    assert (got_d === exp_d) else begin
      n_err++;
      $error("FAIL %s digits: got %h want %h", tag, got_d, exp_d);
    end
    n_cmp++;
    assert (mode === exp_m) else begin
      n_err++;
      $error("FAIL %s mode: got %b want %b", tag, mode, exp_m);
    end
    n_cmp++;
    assert (blank === exp_b) else begin
      n_err++;
      $error("FAIL %s blank: got %b want %b", tag, blank, exp_b);
    end
  endtask

  task automatic check_val(input string tag, input logic [23:0] got, input logic [23:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic cycle(input logic tk, input logic md, input logic ic, input string tag);
    tick     = tk;
    btn_mode = md;
    btn_inc  = ic;
    @(posedge clk);
    model_step(tk, md, ic);
    #1;
    tick     = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    check(tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    tick     = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 61 ticks in RUN, random idle gaps, btn_inc ignored
    for (int i = 0; i < 61; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++)
        cycle(1'b0, 1'b0, 1'(($urandom % 3) == 0), "run_idle");
      cycle(1'b1, 1'b0, 1'(($urandom % 3) == 0), "run_tick");
    end
    check_val("run_61", {h_tens, h_units, m_tens, m_units, s_tens, s_units}, 24'h000101);
    check_val("run_61_mode_blank", {16'h0, mode, blank}, 24'h0);

    // edit to 23:59, exit, 60 ticks wrap to 00:00:00
    cycle(1'b0, 1'b1, 1'b0, "to_set_hr");
    for (int i = 0; i < 24 && (t_sec / 3600) != 23; i++) cycle(1'b0, 1'b0, 1'b1, "hr_to_23");
    cycle(1'b0, 1'b1, 1'b0, "to_set_min");
    for (int i = 0; i < 60 && ((t_sec / 60) % 60) != 59; i++) cycle(1'b0, 1'b0, 1'b1, "min_to_59");
    cycle(1'b0, 1'b1, 1'b0, "exit_2359");
    check_val("preload_2359", {h_tens, h_units, m_tens, m_units, s_tens, s_units}, 24'h235900);
    for (int i = 0; i < 60; i++) begin
      cycle(1'b1, 1'b0, 1'b0, "wrap_tick");
      n_cmp++;
      assert (h_tens <= 4'd2 && !(h_tens == 4'd2 && h_units > 4'd3)) else begin
        n_err++;
        $error("FAIL hour_legal: got %h%h want <=23", h_tens, h_units);
      end
    end
    check_val("wrap_000000", {h_tens, h_units, m_tens, m_units, s_tens, s_units}, 24'h000000);

    // SET_HR from 21, 5 incs with interleaved ticks -> 02
    cycle(1'b0, 1'b1, 1'b0, "set_hr2");
    for (int i = 0; i < 24 && (t_sec / 3600) != 21; i++) cycle(1'b0, 1'b0, 1'b1, "hr_to_21");
    for (int i = 0; i < 5; i++) begin
      if ($urandom % 2 == 1) cycle(1'b1, 1'b0, 1'b0, "set_hr_tick");
      cycle(1'b0, 1'b0, 1'b1, "hr_inc");
    end
    check_val("hr_02", {8'h0, h_tens, h_units, mode, 6'b0}, {8'h0, 8'h02, 2'b01, 6'b0});

    // SET_MIN from 58, 3 incs -> 01, exit clears seconds, then one tick
    cycle(1'b0, 1'b1, 1'b0, "to_set_min2");
    for (int i = 0; i < 60 && ((t_sec / 60) % 60) != 58; i++) cycle(1'b0, 1'b0, 1'b1, "min_to_58");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, "min_inc");
    check_val("min_01", {8'h0, h_tens, h_units, m_tens, m_units}, 24'h000201);
    cycle(1'b0, 1'b1, 1'b0, "exit_min");
    check_val("exit_secs", {14'h0, mode, s_tens, s_units}, 24'h0);
    cycle(1'b1, 1'b0, 1'b0, "after_exit_tick");
    check_val("secs_01", {16'h0, s_tens, s_units}, 24'h000001);

    // blink behaviour in SET_HR
    cycle(1'b0, 1'b1, 1'b0, "blink_enter");
    cycle(1'b1, 1'b0, 1'b0, "blink_t1");
    check_val("blink_on", {18'h0, blank}, {18'h0, 6'b110000});
    cycle(1'b1, 1'b0, 1'b0, "blink_t2");
    check_val("blink_off", {18'h0, blank}, 24'h0);
    cycle(1'b1, 1'b0, 1'b0, "blink_t3");
    cycle(1'b0, 1'b0, 1'b1, "blink_inc");
    check_val("blink_inc_clear", {18'h0, blank}, 24'h0);
    cycle(1'b1, 1'b0, 1'b0, "blink_t4");
    cycle(1'b0, 1'b1, 1'b1, "mode_and_inc");
    check_val("mode_wins", {22'h0, mode}, {22'h0, 2'b10});
    cycle(1'b1, 1'b0, 1'b0, "min_blink");
    cycle(1'b0, 1'b1, 1'b0, "blink_exit");

    // set-mode timeout (or indefinite hold)
    cycle(1'b0, 1'b1, 1'b0, "to_enter");
    for (int i = 1; i <= 100; i++) begin
      cycle(1'b1, 1'b0, 1'b0, "to_tick");
      if (i == TO) begin
`ifdef CLOCK_SET_TIMEOUT_EN
        check_val("timeout_exit", {14'h0, mode, s_tens, s_units}, 24'h0);
`else
        check_val("no_timeout_30", {22'h0, mode}, {22'h0, 2'b01});
`endif
      end
    end
`ifdef CLOCK_SET_TIMEOUT_EN
    check_val("timeout_run_100", {22'h0, mode}, 24'h0);
`else
    check_val("no_timeout_100", {22'h0, mode}, {22'h0, 2'b01});
    cycle(1'b0, 1'b1, 1'b0, "leave_hr");
    cycle(1'b0, 1'b1, 1'b0, "leave_min");
`endif

    // random mixed traffic
    for (int i = 0; i < 500; i++)
      cycle(1'(($urandom % 3) == 0), 1'(($urandom % 10) == 0), 1'(($urandom % 4) == 0), "random");

    // asynchronous reset mid-edit
    if (m_mode != 0) begin
      cycle(1'b0, 1'b1, 1'b0, "pre_rst_a");
      if (m_mode != 0) cycle(1'b0, 1'b1, 1'b0, "pre_rst_b");
    end
    cycle(1'b0, 1'b1, 1'b0, "edit_enter");
    cycle(1'b0, 1'b0, 1'b1, "edit_inc");
    cycle(1'b1, 1'b0, 1'b0, "edit_tick");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, "post_reset_tick");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
